// File: rtl/dot_pkg.sv
// Shared constants and types for the dot-product host sequencer.
package dot_pkg;

    localparam int DOT_N_IN   = 20;
    localparam int DOT_N_OUT  = 10;
    localparam int DOT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    typedef logic [31:0] fp32_t;

endpackage

// File: rtl/axis_seq_buf.sv
// Word buffer: synchronous write, registered read with write-first bypass.
// Out-of-range writes are dropped and out-of-range reads return zero.
module axis_seq_buf #(
    parameter int DEPTH = 20,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-cycle write to the read index is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr > LAST_ADDR) begin
            rd_data <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_dot_host_seq.sv
// Host-side sequencer for the dot-product accelerator: sends the input
// vector on TX, gathers results from RX, reports status and run time.
//
// Handshakes: a word transfers on a rising edge where VALID and READY are
// both high. TX holds TDATA/TLAST stable while TVALID=1 and TREADY=0; TVALID
// never depends on TREADY. RX_AXIS_TREADY is high only in RECV.
module axis_dot_host_seq
    import dot_pkg::*;
#(
    parameter int N_IN    = DOT_N_IN,
    parameter int N_OUT   = DOT_N_OUT,
    parameter int DATA_W  = DOT_DATA_W,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 44100
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic [$clog2(N_IN)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(N_OUT)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_last,
    output logic                     err_timeout,
    output logic [CNT_W-1:0]         cycles,
    output logic [1:0]               state_dbg,
    output logic [DATA_W-1:0]        TX_AXIS_TDATA,
    output logic                     TX_AXIS_TLAST,
    output logic                     TX_AXIS_TVALID,
    input  logic                     TX_AXIS_TREADY,
    input  logic [DATA_W-1:0]        RX_AXIS_TDATA,
    input  logic                     RX_AXIS_TLAST,
    input  logic                     RX_AXIS_TVALID,
    output logic                     RX_AXIS_TREADY
);

    localparam int IN_AW  = $clog2(N_IN);
    localparam int OUT_AW = $clog2(N_OUT);
    localparam logic [IN_AW-1:0]  IDX_LAST  = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] RIDX_LAST = OUT_AW'(N_OUT - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);

    seq_state_t        state, state_n;
    logic [IN_AW-1:0]  idx, idx_n, tx_raddr;
    logic [OUT_AW-1:0] ridx, ridx_n;
    logic [CNT_W-1:0]  cycles_n, cnt_inc;
    logic              err_last_n, err_timeout_n;
    logic              start_ok, tx_hs, rx_hs, hit_timeout;

    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign tx_hs       = (state == SEND) && TX_AXIS_TREADY;
    assign rx_hs       = (state == RECV) && RX_AXIS_TVALID;
    assign cnt_inc     = (&cycles) ? cycles : cycles + 1'b1;
    assign hit_timeout = ((state == SEND) || (state == RECV)) && (cnt_inc == CNT_LIMIT);

    assign busy           = (state == SEND) || (state == RECV);
    assign done           = (state == DONE);
    assign state_dbg      = state;
    assign TX_AXIS_TVALID = (state == SEND);
    assign TX_AXIS_TLAST  = (state == SEND) && (idx == IDX_LAST);
    assign RX_AXIS_TREADY = (state == RECV);

    // Input vector; the host port is locked out while a run is in flight.
    // Its read side prefetches the word TX will present next cycle.
    axis_seq_buf #(.DEPTH(N_IN), .W(DATA_W)) u_inbuf (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (tx_raddr),
        .rd_data (TX_AXIS_TDATA)
    );

    // Result vector, written by RX handshakes, read by the host.
    axis_seq_buf #(.DEPTH(N_OUT), .W(DATA_W)) u_resbuf (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (rx_hs),
        .wr_addr (ridx),
        .wr_data (RX_AXIS_TDATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State, indices, counter and sticky error flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            idx         <= '0;
            ridx        <= '0;
            cycles      <= '0;
            err_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            ridx        <= ridx_n;
            cycles      <= cycles_n;
            err_last    <= err_last_n;
            err_timeout <= err_timeout_n;
        end
    end

    // Next-state logic and inbuf read address selection.
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        ridx_n        = ridx;
        cycles_n      = cycles;
        err_last_n    = err_last;
        err_timeout_n = err_timeout;
        tx_raddr      = idx;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_n       = SEND;
                    idx_n         = '0;
                    ridx_n        = '0;
                    cycles_n      = '0;
                    err_last_n    = 1'b0;
                    err_timeout_n = 1'b0;
                    tx_raddr      = '0;
                end
            end
            SEND: begin
                cycles_n = cnt_inc;
                if (tx_hs) begin
                    idx_n    = idx + 1'b1;
                    tx_raddr = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = RECV;
                    end
                end
                if (hit_timeout) begin
                    state_n       = DONE;
                    err_timeout_n = 1'b1;
                end
            end
            RECV: begin
                cycles_n = cnt_inc;
                if (rx_hs) begin
                    ridx_n = ridx + 1'b1;
                    if ((ridx == RIDX_LAST) || RX_AXIS_TLAST) begin
                        state_n    = DONE;
                        err_last_n = !((ridx == RIDX_LAST) && RX_AXIS_TLAST);
                    end
                end
                if (hit_timeout && (state_n != DONE)) begin
                    state_n       = DONE;
                    err_timeout_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_dot_host_seq.sv
// Directed bench for axis_dot_host_seq with an accelerator stand-in that
// echoes the sent vector XOR a per-run salt on the result stream.
module tb_axis_dot_host_seq;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done, err_last, err_timeout;
  logic [31:0] cycles;
  logic [1:0]  state_dbg;
  logic [31:0] tx_tdata;
  logic        tx_tlast, tx_tvalid, tx_tready;
  logic [31:0] rx_tdata;
  logic        rx_tlast, rx_tvalid, rx_tready;

  int checks = 0;
  int errors = 0;

  logic [31:0] vec [20] = '{
    32'h3F7FCC9A, 32'h3E4CCCCD, 32'hBF000000, 32'h40490FDB, 32'h3F800000,
    32'hC0200000, 32'h3DCCCCCD, 32'h41200000, 32'hBE99999A, 32'h3F333333,
    32'h40000000, 32'hC1A00000, 32'h3C23D70A, 32'h42C80000, 32'hBF4CCCCD,
    32'h3EAAAAAB, 32'h40400000, 32'hC0490FDB, 32'h3A83126F, 32'h447A0000
  };
  logic [31:0] exp_q[$];

  localparam logic [31:0] S2 = 32'h1111_1111;
  localparam logic [31:0] S3 = 32'h2222_2222;

  int tx_cnt, tx_bad, tx_unstable, tx_first_c, tx_last_c, rx_cnt, rx_last_c;
  bit timed_out;

  axis_dot_host_seq dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err_last(err_last), .err_timeout(err_timeout),
    .cycles(cycles), .state_dbg(state_dbg),
    .TX_AXIS_TDATA(tx_tdata), .TX_AXIS_TLAST(tx_tlast),
    .TX_AXIS_TVALID(tx_tvalid), .TX_AXIS_TREADY(tx_tready),
    .RX_AXIS_TDATA(rx_tdata), .RX_AXIS_TLAST(rx_tlast),
    .RX_AXIS_TVALID(rx_tvalid), .RX_AXIS_TREADY(rx_tready)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  // ---------------- driver tasks ----------------
  task automatic load_vec;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = vec[i];
    end
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  task automatic read_res(input int a, output logic [31:0] d);
    @(negedge aclk);
    rd_addr = 4'(a);
    @(negedge aclk);
    d = rd_data;
  endtask

  // One run: start pulse (optionally with a same-cycle write), then per-cycle
  // TX ready pattern and RX responses until done, abort or cycle budget.
  task automatic run_seq(input bit toggle, input bit rx_en, input int last_at,
                         input logic [31:0] salt, input int abort_at, input bit inject,
                         input bit sw_en, input logic [4:0] sw_addr, input logic [31:0] sw_data);
    int rx_k; int c; bit prev_stall; bit injected;
    logic [31:0] prev_d; logic prev_l;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(vec[i]);
    tx_cnt = 0; tx_bad = 0; tx_unstable = 0; tx_first_c = -1; tx_last_c = -1;
    rx_cnt = 0; rx_last_c = -1; timed_out = 1'b0;
    rx_k = 0; prev_stall = 1'b0; injected = 1'b0; prev_d = '0; prev_l = 1'b0;
    @(negedge aclk);
    start = 1'b1; wr_en = sw_en; wr_addr = sw_addr; wr_data = sw_data;
    @(negedge aclk);
    start = 1'b0; wr_en = 1'b0;
    c = 0;
    while (1) begin
      if (abort_at >= 0 && tx_cnt == abort_at) begin
        aresetn = 1'b0; tx_tready = 1'b0; rx_tvalid = 1'b0;
        #1;
        return;
      end
      if (done) break;
      if (c >= 50000) begin timed_out = 1'b1; break; end
      tx_tready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      rx_tvalid = rx_en;
      rx_tdata  = vec[rx_k % 20] ^ salt;
      rx_tlast  = (rx_k == last_at);
      start = 1'b0; wr_en = 1'b0;
      if (inject && rx_tready && !injected) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        injected = 1'b1;
      end
      #1;
      if (tx_tvalid && prev_stall && (tx_tdata !== prev_d || tx_tlast !== prev_l))
        tx_unstable++;
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) tx_bad++;
        else if (tx_tdata !== exp_q.pop_front()) tx_bad++;
        if (tx_tlast !== (tx_cnt == 19)) tx_bad++;
        if (tx_first_c < 0) tx_first_c = c;
        tx_last_c = c;
        tx_cnt++;
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_d = tx_tdata; prev_l = tx_tlast;
      if (rx_tready && rx_tvalid) begin rx_k++; rx_cnt++; rx_last_c = c; end
      @(negedge aclk);
      c++;
    end
    start = 1'b0; wr_en = 1'b0; tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    aresetn = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0;
    repeat (3) @(negedge aclk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    checks++; if ({tx_tvalid, tx_tlast, rx_tready, busy, done, err_last, err_timeout} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000", {tx_tvalid, tx_tlast, rx_tready, busy, done, err_last, err_timeout}); end
    checks++; if (cycles !== 32'd0 || rd_data !== 32'd0 || tx_tdata !== 32'd0) begin
      errors++; $display("FAIL reset_data got cycles=%0d rd=%h tx=%h want 0", cycles, rd_data, tx_tdata); end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    load_vec();
    run_seq(1'b0, 1'b1, 9, 32'h0, -1, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_finish got no done want done"); end
    checks++; if (tx_cnt !== 20 || exp_q.size() !== 0) begin errors++; $display("FAIL basic_tx_count got %0d left %0d want 20 left 0", tx_cnt, exp_q.size()); end
    checks++; if (tx_bad !== 0) begin errors++; $display("FAIL basic_tx_words got %0d bad want 0", tx_bad); end
    checks++; if (tx_first_c !== 0 || tx_last_c !== 19) begin errors++; $display("FAIL basic_tx_span got %0d..%0d want 0..19", tx_first_c, tx_last_c); end
    checks++; if (done !== 1'b1 || err_last !== 1'b0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL basic_status got done=%b el=%b et=%b want 1 0 0", done, err_last, err_timeout); end
    checks++; if (cycles !== 32'd30) begin errors++; $display("FAIL basic_cycles got %0d want 30", cycles); end
    for (int k = 0; k < 10; k++) begin
      read_res(k, d);
      checks++; if (d !== vec[k]) begin errors++; $display("FAIL basic_res%0d got %h want %h", k, d, vec[k]); end
    end
    read_res(12, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL basic_rd_oor got %h want 0", d); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    run_seq(1'b1, 1'b1, 9, S2, -1, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (tx_unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", tx_unstable); end
    checks++; if (tx_bad !== 0 || tx_cnt !== 20 || exp_q.size() !== 0) begin
      errors++; $display("FAIL bp_words got bad=%0d cnt=%0d want 0 20", tx_bad, tx_cnt); end
    checks++; if (tx_last_c !== 39) begin errors++; $display("FAIL bp_last_tx got %0d want 39", tx_last_c); end
    checks++; if (cycles !== 32'd50) begin errors++; $display("FAIL bp_cycles got %0d want 50", cycles); end
    checks++; if (cycles !== 32'(rx_last_c - tx_first_c + 1)) begin
      errors++; $display("FAIL bp_span got %0d want %0d", cycles, rx_last_c - tx_first_c + 1); end
    read_res(9, d);
    checks++; if (d !== (vec[9] ^ S2)) begin errors++; $display("FAIL bp_res9 got %h want %h", d, vec[9] ^ S2); end
  endtask

  task automatic test_early_last;
    logic [31:0] d;
    run_seq(1'b0, 1'b1, 5, S3, -1, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (err_last !== 1'b1 || done !== 1'b1 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL early_status got el=%b done=%b et=%b want 1 1 0", err_last, done, err_timeout); end
    checks++; if (rx_cnt !== 6) begin errors++; $display("FAIL early_rx_count got %0d want 6", rx_cnt); end
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("FAIL early_tready got %b want 0", rx_tready); end
    checks++; if (cycles !== 32'd26) begin errors++; $display("FAIL early_cycles got %0d want 26", cycles); end
    for (int k = 0; k < 10; k++) begin
      read_res(k, d);
      checks++; if (d !== (vec[k] ^ ((k < 6) ? S3 : S2))) begin
        errors++; $display("FAIL early_res%0d got %h want %h", k, d, vec[k] ^ ((k < 6) ? S3 : S2)); end
    end
  endtask

  task automatic test_timeout;
    run_seq(1'b0, 1'b0, 9, 32'h0, -1, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (timed_out) begin errors++; $display("FAIL to_finish got no done want done"); end
    checks++; if (err_timeout !== 1'b1 || done !== 1'b1 || err_last !== 1'b0) begin
      errors++; $display("FAIL to_status got et=%b done=%b el=%b want 1 1 0", err_timeout, done, err_last); end
    checks++; if (cycles !== 32'd44100) begin errors++; $display("FAIL to_cycles got %0d want 44100", cycles); end
    checks++; if (tx_tvalid !== 1'b0 || rx_tready !== 1'b0) begin
      errors++; $display("FAIL to_lines got tv=%b rr=%b want 0 0", tx_tvalid, rx_tready); end
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL to_rx_count got %0d want 0", rx_cnt); end
  endtask

  task automatic test_reset_mid_send;
    logic [31:0] d;
    run_seq(1'b0, 1'b1, 9, 32'h0, 7, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (tx_cnt !== 7) begin errors++; $display("FAIL rst_at_word got %0d want 7", tx_cnt); end
    checks++; if ({tx_tvalid, tx_tlast, rx_tready, busy, done, err_last, err_timeout} !== 7'd0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL rst_flags got %b st=%0d want 0", {tx_tvalid, tx_tlast, rx_tready, busy, done, err_last, err_timeout}, state_dbg); end
    checks++; if (cycles !== 32'd0 || rd_data !== 32'd0 || tx_tdata !== 32'd0) begin
      errors++; $display("FAIL rst_data got cycles=%0d rd=%h tx=%h want 0", cycles, rd_data, tx_tdata); end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      read_res(k, d);
      checks++; if (d !== (vec[k] ^ ((k < 6) ? S3 : S2))) begin
        errors++; $display("FAIL rst_keep%0d got %h want %h", k, d, vec[k] ^ ((k < 6) ? S3 : S2)); end
    end
    run_seq(1'b0, 1'b1, 9, 32'h0, -1, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (tx_bad !== 0 || tx_cnt !== 20 || tx_first_c !== 0) begin
      errors++; $display("FAIL rst_rerun got bad=%0d cnt=%0d first=%0d want 0 20 0", tx_bad, tx_cnt, tx_first_c); end
    checks++; if (done !== 1'b1 || err_last !== 1'b0 || cycles !== 32'd30) begin
      errors++; $display("FAIL rst_rerun_status got done=%b el=%b cycles=%0d want 1 0 30", done, err_last, cycles); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] d;
    run_seq(1'b0, 1'b1, 9, S2, -1, 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (done !== 1'b1 || err_last !== 1'b0 || err_timeout !== 1'b0 || rx_cnt !== 10) begin
      errors++; $display("FAIL busy_run got done=%b el=%b et=%b rx=%0d want 1 0 0 10", done, err_last, err_timeout, rx_cnt); end
    checks++; if (cycles !== 32'd30) begin errors++; $display("FAIL busy_cycles got %0d want 30", cycles); end
    // Rerun with a write to word 0 landing on the start cycle.
    vec[0] = 32'h42280000;
    run_seq(1'b0, 1'b1, 9, 32'h0, -1, 1'b0, 1'b1, 5'd0, 32'h42280000);
    checks++; if (tx_bad !== 0 || tx_cnt !== 20 || exp_q.size() !== 0) begin
      errors++; $display("FAIL busy_rerun_words got bad=%0d cnt=%0d want 0 20", tx_bad, tx_cnt); end
    read_res(0, d);
    checks++; if (d !== 32'h42280000) begin errors++; $display("FAIL busy_res0 got %h want 42280000", d); end
    read_res(3, d);
    checks++; if (d !== vec[3]) begin errors++; $display("FAIL busy_res3 got %h want %h", d, vec[3]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_timeout();
    test_reset_mid_send();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_dot_host_seq.md
Name: axis_dot_host_seq

Overview:
- Stream-side sequencer that drives the matrix-vector accelerator (20-in/10-out dot-product engine) from the host end of its AXI4-Stream interfaces.
- The host loads a 32-bit IEEE-754 vector into a local buffer and pulses start. The block then:
  - streams the vector out with TLAST on the final word;
  - collects the result stream into a result buffer;
  - reports done, error flags and the cycle count.
- It replaces the software/bench producer-consumer pair so the accelerator can be run and timed in hardware.

Parameters:
- N_IN, 20, number of words sent per run (input vector length).
- N_OUT, 10, number of words expected back per run.
- DATA_W, 32, stream and buffer word width.
- CNT_W, 32, width of the cycle counter.
- TIMEOUT, 44100, cycle limit per run before abort.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- wr_en  in  1  input-buffer write strobe; ignored while busy.
- wr_addr  in  $clog2(N_IN)  input-buffer write index.
- wr_data  in  DATA_W  input-buffer write data.
- rd_addr  in  $clog2(N_OUT)  result-buffer read index.
- rd_data  out  DATA_W  result word; registered, 1-cycle latency.
- busy  out  1  high in SEND or RECV.
- done  out  1  high in DONE.
- err_last  out  1  TLAST position mismatch seen on the result stream.
- err_timeout  out  1  run aborted because the cycle limit was hit.
- cycles  out  CNT_W  cycles from run start to the last result handshake.
- TX_AXIS_TDATA  out  DATA_W  vector word to the accelerator's input stream.
- TX_AXIS_TLAST  out  1  high on word N_IN-1.
- TX_AXIS_TVALID  out  1  valid.
- TX_AXIS_TREADY  in  1  accelerator ready.
- RX_AXIS_TDATA  in  DATA_W  result word from the accelerator's output stream.
- RX_AXIS_TLAST  in  1  last result.
- RX_AXIS_TVALID  in  1  valid.
- RX_AXIS_TREADY  out  1  sequencer ready.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - State goes to IDLE.
  - TX_AXIS_TVALID, TX_AXIS_TLAST, RX_AXIS_TREADY, busy, done, err_last, err_timeout = 0.
  - cycles = 0, rd_data = 0, TX_AXIS_TDATA = 0.
  - Buffer contents are not cleared.
  - Reset mid-run aborts immediately. No further handshakes occur and the next run starts clean.
- States: IDLE -> SEND -> RECV -> DONE. DONE -> SEND on start. IDLE -> SEND on start.
- start accepted (rising clock edge with start=1 in IDLE or DONE):
  - clear done, err_last, err_timeout and cycles;
  - set the send index to 0;
  - enter SEND;
  - TX_AXIS_TVALID rises on the following cycle with word 0.
- SEND:
  - TX_AXIS_TVALID=1 and TDATA = inbuf[idx]; TLAST = (idx==N_IN-1).
  - TDATA and TLAST are held stable until TX_AXIS_TREADY=1 is sampled.
  - Each handshake increments idx and presents the next word on the next cycle with no bubble, which gives one word per cycle when TREADY stays high.
  - A handshake on idx==N_IN-1 drops TVALID and TLAST and enters RECV.
- RECV:
  - RX_AXIS_TREADY=1. Each handshake writes resbuf[ridx] and increments ridx.
  - Handshake with ridx==N_OUT-1 and TLAST=1: normal end, go to DONE.
  - TLAST=1 with ridx<N_OUT-1: set err_last and go to DONE; the word is stored.
  - ridx==N_OUT-1 with TLAST=0: set err_last and go to DONE.
  - RX_AXIS_TREADY is deasserted in the cycle after the terminating handshake.
- RX traffic in IDLE, SEND or DONE is not accepted: RX_AXIS_TREADY=0.
- cycles:
  - Increments every cycle in SEND or RECV, starting from 1 on the first SEND cycle.
  - Freezes on entry to DONE.
  - Saturates at all-ones.
- Timeout: if cycles reaches TIMEOUT in SEND or RECV:
  - set err_timeout;
  - force TX_AXIS_TVALID and RX_AXIS_TREADY low;
  - go to DONE.
- Buffers:
  - wr_en writes inbuf in IDLE and DONE only; it is dropped in SEND and RECV.
  - Out-of-range wr_addr or rd_addr: writes are ignored and reads return 0.
  - rd_data is valid at any time and reflects the last completed write to that index.
- Simultaneous events:
  - start together with wr_en in IDLE: the write lands first, so the new word is sent.
  - start while busy: ignored.

Decomposition:
- Shared package dot_pkg holds:
  - DOT_N_IN=20, DOT_N_OUT=10, DOT_DATA_W=32;
  - typedef enum seq_state_t {IDLE, SEND, RECV, DONE};
  - typedef logic [31:0] fp32_t.
- One sub-module, axis_seq_buf: a parameterised synchronous-write, registered-read word buffer, instantiated twice (inbuf and resbuf).

Test Plan:
1. Load the 20 test vector words (word 0 = 0x3F7FCC9A); start; TX_AXIS_TREADY=1; loopback model returns 10 words with TLAST on #9.
   - Required: 20 TX handshakes on consecutive cycles, TLAST only on #19.
   - Required: resbuf[0..9] match the sent values; done=1; err flags=0.
2. TX_AXIS_TREADY toggles 1,0,0,1 repeating.
   - Required: TDATA and TLAST stable while TREADY=0; no word skipped or repeated.
   - Required: cycles equals the measured handshake span.
3. Result stream asserts TLAST on word #5.
   - Required: err_last=1, done=1, 6 words stored, RX_AXIS_TREADY=0 afterwards.
4. Accelerator never asserts RX_AXIS_TVALID.
   - Required: err_timeout=1 and done=1 at cycles=44100; TVALID and TREADY low.
5. Assert aresetn=0 mid-SEND at word 7.
   - Required: all outputs return to reset values immediately.
   - Required: a new start resends from word 0, and stored data is intact.
6. Issue start and wr_en during RECV.
   - Required: both ignored; the run completes; inbuf is unchanged when read back through a rerun.
